imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator for the decode stage of the RV32I/RV64I pipeline.
- Accepts one instruction per cycle on a valid/ready handshake and extracts and sign-extends the immediate to XLEN bits.
- Classifies the immediate format and flags malformed encodings.
- Presents results one cycle later through a 2-entry skid buffer, so ID-stage backpressure never drops or duplicates an instruction.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Sets immediate width and shift-amount width.
- PASS_W, 32, width of the opaque sideband (for example PC tag) carried alongside each instruction.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous kill of all buffered entries (branch mispredict)
- in_valid  in  1  inst_code/in_side valid
- in_ready  out  1  block can accept this cycle
- inst_code  in  32  instruction word
- in_side  in  PASS_W  sideband, returned unchanged
- out_valid  out  1  output entry valid
- out_ready  in  1  consumer accepts this cycle
- out_imm  out  XLEN  generated immediate
- out_fmt  out  3  format code (imm_pkg::imm_fmt_e)
- out_illegal  out  1  malformed encoding detected
- out_inst  out  32  instruction word that produced out_imm
- out_side  out  PASS_W  sideband

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: out_valid=0, in_ready=1, out_imm=0, out_fmt=FMT_NONE, out_illegal=0, out_inst=0, out_side=0. Both buffer entries are invalid.
- Latency and throughput:
  - An instruction accepted at edge N (in_valid & in_ready) is visible on the outputs after edge N, provided the output register was empty or drained at N.
  - Throughput is 1 per cycle.
- Buffering:
  - Storage is a main output register plus one skid entry.
  - in_ready = !skid_valid, driven straight from a register with no combinational path from out_ready.
  - When the main register is occupied and not drained, an accepted instruction goes to skid.
  - When main drains, skid moves to main on the same edge. Order is strictly FIFO.
  - Accept and drain in the same cycle with skid empty: main reloads directly and skid stays empty.
- Flush:
  - Clears main and skid valid on the next edge.
  - An in_valid asserted in the same cycle as flush is dropped.
  - in_ready=1 on the following cycle.
- Reset mid-operation behaves identically to flush, and also zeroes all output payload registers.
- Held outputs: out_* remain stable while out_valid & !out_ready.
- Format decode, by inst_code[6:0]:
  - LOAD 0000011, OP-IMM 0010011 (non-shift), JALR 1100111: FMT_I, sign-extend inst[31:20].
  - OP-IMM with funct3 001 or 101: FMT_SHAMT, zero-extend inst[SHW+19:20], where SHW=5 for XLEN=32 and 6 for XLEN=64.
    - Illegal if XLEN=32 and inst[25]=1.
    - Illegal if funct7[6:1] (with SHW=6) or funct7 (with SHW=5) is not 0 or 0b010000x/0100000.
    - Illegal if funct3=001 and funct7 is not 0.
  - STORE 0100011: FMT_S, sign-extend {inst[31:25], inst[11:7]}.
  - BRANCH 1100011: FMT_B, sign-extend {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - JAL 1101111: FMT_J, sign-extend {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - LUI 0110111, AUIPC 0010111: FMT_U, {inst[31:12], 12'b0}, sign-extended to XLEN from bit 31.
  - SYSTEM 1110011 with funct3 != 0: FMT_CSR, zero-extend inst[19:15] (zimm). With funct3=0: FMT_NONE, imm 0.
  - Any other opcode: FMT_NONE, imm 0, illegal=0 (the main decoder owns opcode legality).
  - inst[1:0] != 2'b11: illegal=1 regardless of opcode; imm is still computed.
- Width rule: every extension is performed to exactly XLEN. No X or undriven bits for any opcode.

Decomposition:
- imm_pkg holds:
  - imm_fmt_e: NONE=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6, CSR=7.
  - The 7-bit opcode localparams.
  - The shamt_width(XLEN) function.
- Sub-module imm_extract: purely combinational. Takes inst_code and produces imm, fmt and illegal, parametrised by XLEN.
- imm_gen_pipe instantiates imm_extract on the input side and owns the register, skid and handshake logic.

Test Plan:
1. XLEN=32, stream 0xFFF00093 (addi -1), 0x123450B7 (lui), 0xFE000CE3 (beq -8) with out_ready=1 -> outputs one cycle after each accept: 0xFFFFFFFF/I, 0x12345000/U, 0xFFFFFFF8/B, back-to-back.
2. XLEN=32, 0x4030D093 (srai 3) -> imm 3, SHAMT, illegal=0. Then 0x4200D093 -> illegal=1.
3. XLEN=64, 0x4200D093 -> imm 0x20, illegal=0. Then 0x800000B7 -> imm 0xFFFFFFFF80000000.
4. Backpressure: out_ready=0 for 3 cycles while in_valid streams A, B, C -> A and B accepted, in_ready=0 while C is held. Release -> A, B, C emerge in order, each exactly once, with sideband intact.
5. Fill both entries, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the concurrent instruction never appears.
6. Assert reset with both entries full -> after one edge all outputs are at reset values. 0x00000013 (nop) issued next -> imm 0, FMT_I, 1-cycle latency. 0x00000010 (inst[1:0]=00) -> illegal=1.

Source files
------------

// File: rtl/imm_pkg.sv
// imm_pkg: immediate format codes, RV opcodes and shift-amount width helper
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_NONE  = 3'd0,
      FMT_I     = 3'd1,
      FMT_S     = 3'd2,
      FMT_B     = 3'd3,
      FMT_U     = 3'd4,
      FMT_J     = 3'd5,
      FMT_SHAMT = 3'd6,
      FMT_CSR   = 3'd7
   } imm_fmt_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   function automatic int shamt_width(input int xlen);
      return (xlen == 64) ? 6 : 5;
   endfunction

endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational immediate extraction, format classification and malformed-encoding check
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst_code,
   output logic [XLEN-1:0] imm,
   output imm_fmt_e        fmt,
   output logic            illegal
);

   localparam int SHW = shamt_width(XLEN);

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [5:0]  hi;
   logic        sh_bad;
   logic [63:0] w;

   assign opc = inst_code[6:0];
   assign f3  = inst_code[14:12];
   assign hi  = inst_code[31:26];

   // Built at 64 bits and truncated, so both XLEN values share one sign-extension path
   always_comb begin
      fmt = FMT_NONE;
      w   = '0;
      case (opc)
         OPC_LOAD, OPC_JALR: fmt = FMT_I;
         OPC_OP_IMM:         fmt = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SHAMT : FMT_I;
         OPC_STORE:          fmt = FMT_S;
         OPC_BRANCH:         fmt = FMT_B;
         OPC_JAL:            fmt = FMT_J;
         OPC_LUI, OPC_AUIPC: fmt = FMT_U;
         OPC_SYSTEM:         fmt = (f3 != 3'b000) ? FMT_CSR : FMT_NONE;
         default:            fmt = FMT_NONE;
      endcase
      case (fmt)
         FMT_I:     w = {{52{inst_code[31]}}, inst_code[31:20]};
         FMT_S:     w = {{52{inst_code[31]}}, inst_code[31:25], inst_code[11:7]};
         FMT_B:     w = {{52{inst_code[31]}}, inst_code[7], inst_code[30:25], inst_code[11:8], 1'b0};
         FMT_J:     w = {{44{inst_code[31]}}, inst_code[19:12], inst_code[20], inst_code[30:21], 1'b0};
         FMT_U:     w = {{32{inst_code[31]}}, inst_code[31:12], 12'b0};
         FMT_SHAMT: w = {58'b0, (SHW == 6) & inst_code[25], inst_code[24:20]};
         FMT_CSR:   w = {59'b0, inst_code[19:15]};
         default:   w = '0;
      endcase
   end

   // inst[25] is shamt[5] on RV64 and must be zero on RV32; bits above it select srli/srai
   assign sh_bad  = ((SHW == 5) && inst_code[25]) ||
                    (hi != 6'b000000 && hi != 6'b010000) ||
                    (f3 == 3'b001 && hi != 6'b000000);
   assign illegal = (inst_code[1:0] != 2'b11) || (fmt == FMT_SHAMT && sh_bad);
   assign imm     = XLEN'(w);

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with main register plus skid entry on a valid/ready handshake
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int PASS_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       inst_code,
   input  logic [PASS_W-1:0] in_side,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_imm,
   output imm_fmt_e          out_fmt,
   output logic              out_illegal,
   output logic [31:0]       out_inst,
   output logic [PASS_W-1:0] out_side
);

   typedef struct packed {
      logic [XLEN-1:0]   imm;
      imm_fmt_e          fmt;
      logic              ill;
      logic [31:0]       inst;
      logic [PASS_W-1:0] side;
   } ent_t;

   logic [XLEN-1:0] x_imm;
   imm_fmt_e        x_fmt;
   logic            x_ill;
   ent_t            in_e, main_q, main_d, skid_q, skid_d;
   logic            mv_q, mv_d, sv_q, sv_d, take, free;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .inst_code (inst_code),
      .imm       (x_imm),
      .fmt       (x_fmt),
      .illegal   (x_ill)
   );

   assign in_e = '{imm: x_imm, fmt: x_fmt, ill: x_ill, inst: inst_code, side: in_side};
   assign take = in_valid & ~sv_q & ~flush;
   assign free = ~mv_q | out_ready;

   // Skid is only ever occupied while main is held, so a free main always takes skid first
   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      mv_d   = mv_q;
      sv_d   = sv_q;
      if (flush) begin
         mv_d = 1'b0;
         sv_d = 1'b0;
      end else if (free) begin
         mv_d   = sv_q | take;
         main_d = sv_q ? skid_q : (take ? in_e : main_q);
         sv_d   = 1'b0;
      end else if (take) begin
         skid_d = in_e;
         sv_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mv_q   <= 1'b0;
         sv_q   <= 1'b0;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         mv_q   <= mv_d;
         sv_q   <= sv_d;
         main_q <= main_d;
         skid_q <= skid_d;
      end
   end

   assign in_ready    = ~sv_q;
   assign out_valid   = mv_q;
   assign out_imm     = main_q.imm;
   assign out_fmt     = main_q.fmt;
   assign out_illegal = main_q.ill;
   assign out_inst    = main_q.inst;
   assign out_side    = main_q.side;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: XLEN=32 and XLEN=64 instances on shared stimulus, checked against a queue model each cycle
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [31:0] inst_code, in_side;
   logic        rdy32, rdy64, ov32, ov64, il32, il64;
   logic [2:0]  fm32, fm64;
   logic [31:0] imm32, ins32, sd32, ins64, sd64;
   logic [63:0] imm64;
   int          total = 0;
   int          bad = 0;
   bit          chk_en = 0;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] side;
   } item_t;
   item_t q[$];

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .PASS_W(32)) d32 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
      .inst_code(inst_code), .in_side(in_side), .out_valid(ov32), .out_ready(out_ready),
      .out_imm(imm32), .out_fmt(fm32), .out_illegal(il32), .out_inst(ins32), .out_side(sd32)
   );

   imm_gen_pipe #(.XLEN(64), .PASS_W(32)) d64 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
      .inst_code(inst_code), .in_side(in_side), .out_valid(ov64), .out_ready(out_ready),
      .out_imm(imm64), .out_fmt(fm64), .out_illegal(il64), .out_inst(ins64), .out_side(sd64)
   );

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", n, act, exp, $time);
      end
   endtask

   // Reference decode straight from the format table, using signed arithmetic for extension
   function automatic void ref_dec(input logic [31:0] i, input int xlen,
                                   output logic [63:0] imm, output logic [2:0] fmt, output logic ill);
      longint     v = 0;
      int         shw = (xlen == 64) ? 6 : 5;
      logic [2:0] f3 = i[14:12];
      logic [6:0] f7 = i[31:25];
      logic [6:0] fh;
      fmt = 3'd0;
      ill = 1'b0;
      case (i[6:0])
         7'h03, 7'h67: begin fmt = 3'd1; v = longint'($signed(i[31:20])); end
         7'h13: begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
               fmt = 3'd6;
               v = longint'((i >> 20) & ((32'd1 << shw) - 32'd1));
               fh = (shw == 6) ? {1'b0, f7[6:1]} : f7;
               ill = (xlen == 32 && i[25]) ||
                     !(fh == 7'd0 || fh == ((shw == 6) ? 7'b0010000 : 7'b0100000)) ||
                     (f3 == 3'd1 && fh != 7'd0);
            end else begin
               fmt = 3'd1;
               v = longint'($signed(i[31:20]));
            end
         end
         7'h23: begin fmt = 3'd2; v = longint'($signed({i[31:25], i[11:7]})); end
         7'h63: begin fmt = 3'd3; v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
         7'h6F: begin fmt = 3'd5; v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
         7'h37, 7'h17: begin fmt = 3'd4; v = longint'($signed(i & 32'hFFFFF000)); end
         7'h73: if (f3 != 3'd0) begin fmt = 3'd7; v = longint'((i >> 15) & 32'd31); end
         default: ;
      endcase
      if (i[1:0] != 2'b11) ill = 1'b1;
      imm = (xlen == 32) ? {32'b0, v[31:0]} : v;
   endfunction

   // FIFO occupancy model: up to two held entries, head is what the outputs must show
   always @(posedge clk) begin
      bit pop, push;
      if (reset || flush) q.delete();
      else begin
         pop  = (q.size() > 0) && out_ready;
         push = in_valid && (q.size() < 2);
         if (pop) q.delete(0);
         if (push) q.push_back('{inst_code, in_side});
      end
   end

   always @(negedge clk) if (chk_en) begin
      logic [63:0] ei;
      logic [2:0]  ef;
      logic        el;
      chk("valid32", 64'(ov32), 64'(q.size() > 0));
      chk("valid64", 64'(ov64), 64'(q.size() > 0));
      chk("ready32", 64'(rdy32), 64'(q.size() < 2));
      chk("ready64", 64'(rdy64), 64'(q.size() < 2));
      if (q.size() > 0) begin
         ref_dec(q[0].inst, 32, ei, ef, el);
         chk("imm32", 64'(imm32), ei);
         chk("fmt32", 64'(fm32), 64'(ef));
         chk("ill32", 64'(il32), 64'(el));
         chk("inst32", 64'(ins32), 64'(q[0].inst));
         chk("side32", 64'(sd32), 64'(q[0].side));
         ref_dec(q[0].inst, 64, ei, ef, el);
         chk("imm64", imm64, ei);
         chk("fmt64", 64'(fm64), 64'(ef));
         chk("ill64", 64'(il64), 64'(el));
         chk("inst64", 64'(ins64), 64'(q[0].inst));
         chk("side64", 64'(sd64), 64'(q[0].side));
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [31:0] ins, input logic [31:0] sd);
      in_valid = 1'b1;
      inst_code = ins;
      in_side = sd;
   endtask

   logic [31:0] tbl [10] = '{32'hFF5FF0EF, 32'hFE112E23, 32'h3402D073, 32'h00000073, 32'hFFFFF117,
                             32'h00209093, 32'h02209093, 32'h00008067, 32'hFF813083, 32'h0000006B};

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      inst_code = '0; in_side = '0;
      tick; tick;
      reset = 1'b0;
      chk_en = 1;
      chk("rst_valid", 64'(ov32), 64'd0);
      chk("rst_ready", 64'(rdy32), 64'd1);
      chk("rst_imm", imm64, 64'd0);

      // back-to-back stream with consumer always ready
      out_ready = 1'b1;
      put(32'hFFF00093, 32'h11); tick;
      chk("t1_addi", 64'(imm32), 64'hFFFFFFFF);
      chk("t1_addi_fmt", 64'(fm32), 64'd1);
      put(32'h123450B7, 32'h22); tick;
      chk("t1_lui", 64'(imm32), 64'h12345000);
      chk("t1_lui_fmt", 64'(fm32), 64'd4);
      put(32'hFE000CE3, 32'h33); tick;
      chk("t1_beq", 64'(imm32), 64'hFFFFFFF8);
      chk("t1_beq_fmt", 64'(fm32), 64'd3);
      chk("t1_beq_valid", 64'(ov32), 64'd1);

      // shift-amount legality differs between widths
      put(32'h4030D093, 32'h44); tick;
      chk("t2_srai", 64'(imm32), 64'd3);
      chk("t2_srai_fmt", 64'(fm32), 64'd6);
      chk("t2_srai_ill", 64'(il32), 64'd0);
      put(32'h4200D093, 32'h55); tick;
      chk("t2_srai32_ill", 64'(il32), 64'd1);
      chk("t3_srai64", imm64, 64'h20);
      chk("t3_srai64_ill", 64'(il64), 64'd0);
      put(32'h800000B7, 32'h66); tick;
      chk("t3_lui64", imm64, 64'hFFFFFFFF80000000);
      chk("t3_lui32", 64'(imm32), 64'h80000000);
      in_valid = 1'b0; tick;

      // backpressure: A main, B skid, C held off
      out_ready = 1'b0;
      put(32'h00100093, 32'hA); tick;
      put(32'h00200093, 32'hB); tick;
      put(32'h00300093, 32'hC); tick;
      chk("t4_ready", 64'(rdy32), 64'd0);
      chk("t4_hold_side", 64'(sd32), 64'hA);
      out_ready = 1'b1; tick;
      chk("t4_B_side", 64'(sd32), 64'hB);
      tick;
      chk("t4_C_side", 64'(sd32), 64'hC);
      in_valid = 1'b0; tick;
      chk("t4_empty", 64'(ov32), 64'd0);

      // flush with both entries full and a concurrent instruction
      out_ready = 1'b0;
      put(32'h00400093, 32'hD1); tick;
      put(32'h00500093, 32'hD2); tick;
      put(32'h00600093, 32'hD3); flush = 1'b1; tick;
      flush = 1'b0; in_valid = 1'b0;
      chk("t5_valid", 64'(ov32), 64'd0);
      chk("t5_ready", 64'(rdy32), 64'd1);
      out_ready = 1'b1; tick;
      chk("t5_dropped", 64'(ov64), 64'd0);

      // reset with both entries full zeroes payload
      out_ready = 1'b0;
      put(32'hFFF00093, 32'hE1); tick;
      put(32'hFE000CE3, 32'hE2); tick;
      in_valid = 1'b0; reset = 1'b1; tick;
      reset = 1'b0;
      chk("t6_valid", 64'(ov64), 64'd0);
      chk("t6_ready", 64'(rdy64), 64'd1);
      chk("t6_imm", imm64, 64'd0);
      chk("t6_fmt", 64'(fm64), 64'd0);
      chk("t6_inst", 64'(ins64), 64'd0);
      chk("t6_side", 64'(sd64), 64'd0);
      chk("t6_ill", 64'(il64), 64'd0);
      out_ready = 1'b1;
      put(32'h00000013, 32'hF1); tick;
      chk("t6_nop_valid", 64'(ov32), 64'd1);
      chk("t6_nop_imm", 64'(imm32), 64'd0);
      chk("t6_nop_fmt", 64'(fm32), 64'd1);
      put(32'h00000010, 32'hF2); tick;
      chk("t6_bad_low", 64'(il32), 64'd1);

      // remaining formats under an intermittent consumer
      for (int k = 0; k < 30; k++) begin
         out_ready = (k % 3) != 0;
         if ((k % 4) != 3) put(tbl[k % 10], 32'(k + 256));
         else in_valid = 1'b0;
         tick;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick; tick; tick;
      chk("drain_empty", 64'(ov32), 64'd0);
      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
